// File: rtl/nasti_stream_pkg.sv
// nasti_stream_pkg
//   Shared types and helpers for the NASTI-stream arbiter slice.
//   - arb_state_t : arbiter lock state (IDLE / LOCKED)
//   - pick_t      : result of a round-robin search (found flag + index)
//   - rr_pick()   : round-robin winner search starting after the last grant
//   - idx_width() : index width for an N-entry select, never below 1
package nasti_stream_pkg;

  // Widest request vector rr_pick() can search.
  localparam int unsigned MAX_PORT = 32;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic        found;
    logic [31:0] idx;
  } pick_t;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Searches req[last+1], req[last+2], ... with wrap at n and returns the
  // first requester. last must be below n; n must not exceed MAX_PORT.
  function automatic pick_t rr_pick(input logic [MAX_PORT-1:0] req,
                                    input int unsigned         last,
                                    input int unsigned         n);
    pick_t       r;
    int unsigned i;
    r.found = 1'b0;
    r.idx   = '0;
    for (int unsigned off = 1; off <= MAX_PORT; off++) begin
      if (off <= n) begin
        i = last + off;
        if (i >= n) begin
          i = i - n;
        end
        if (!r.found && req[i]) begin
          r.found = 1'b1;
          r.idx   = i;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/nasti_stream_buf.sv
// nasti_stream_buf
//   Small registered FIFO used as the arbiter output stage.
//   Both in_ready and out_valid are decoded from the registered fill level,
//   so a pop in the same cycle never frees a slot for a push on a full buffer.
// Ports
//   aclk, aresetn        : clock, asynchronous active-low reset (empties FIFO)
//   in_valid/in_ready    : write side handshake, in_data payload
//   out_valid/out_ready  : read side handshake, out_data payload (head entry)
module nasti_stream_buf #(
  parameter  int unsigned WIDTH    = 8,
  parameter  int unsigned BUF_SIZE = 2,
  localparam int unsigned PTR_W    = (BUF_SIZE > 1) ? $clog2(BUF_SIZE) : 1,
  localparam int unsigned CNT_W    = $clog2(BUF_SIZE + 1)
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic [WIDTH-1:0] mem [BUF_SIZE];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_SIZE - 1)) ? '0 : p + 1'b1;
  endfunction

  assign in_ready  = (count != CNT_W'(BUF_SIZE));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_data  = mem[rd_ptr];

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge aclk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

endmodule

// File: rtl/nasti_stream_arbiter.sv
// nasti_stream_arbiter
//   Packet-granular round-robin merge of N_PORT NASTI-stream sources onto a
//   single destination. A grant is held from the first beat of a packet until
//   its t_last beat is accepted, so packets never interleave. With TAG_ID=1
//   the granted port index replaces t_id on the output.
// Ports
//   aclk, areset          : clock, asynchronous active-high reset
//   src_t_*  [N_PORT]     : source stream channels (valid/ready/payload)
//   dest_t_*              : merged stream, driven from a 2-entry buffer
//   grant_idx             : current or most recently granted port
//   locked                : high while a multi-beat packet is in progress
module nasti_stream_arbiter
  import nasti_stream_pkg::*;
#(
  parameter  int unsigned N_PORT     = 4,
  parameter  int unsigned ID_WIDTH   = 2,
  parameter  int unsigned DEST_WIDTH = 1,
  parameter  int unsigned USER_WIDTH = 1,
  parameter  int unsigned DATA_WIDTH = 64,
  parameter  int unsigned TAG_ID     = 1,
  localparam int unsigned IDX_W      = (N_PORT > 1) ? $clog2(N_PORT) : 1,
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                                   aclk,
  input  logic                                   areset,

  input  logic [N_PORT-1:0]                      src_t_valid,
  output logic [N_PORT-1:0]                      src_t_ready,
  input  logic [N_PORT-1:0][DATA_WIDTH-1:0]      src_t_data,
  input  logic [N_PORT-1:0][STRB_WIDTH-1:0]      src_t_strb,
  input  logic [N_PORT-1:0][STRB_WIDTH-1:0]      src_t_keep,
  input  logic [N_PORT-1:0]                      src_t_last,
  input  logic [N_PORT-1:0][ID_WIDTH-1:0]        src_t_id,
  input  logic [N_PORT-1:0][DEST_WIDTH-1:0]      src_t_dest,
  input  logic [N_PORT-1:0][USER_WIDTH-1:0]      src_t_user,

  output logic                                   dest_t_valid,
  input  logic                                   dest_t_ready,
  output logic [DATA_WIDTH-1:0]                  dest_t_data,
  output logic [STRB_WIDTH-1:0]                  dest_t_strb,
  output logic [STRB_WIDTH-1:0]                  dest_t_keep,
  output logic                                   dest_t_last,
  output logic [ID_WIDTH-1:0]                    dest_t_id,
  output logic [DEST_WIDTH-1:0]                  dest_t_dest,
  output logic [USER_WIDTH-1:0]                  dest_t_user,

  output logic [IDX_W-1:0]                       grant_idx,
  output logic                                   locked
);

  localparam int unsigned BEAT_W = DATA_WIDTH + 2 * STRB_WIDTH + 1 +
                                   ID_WIDTH + DEST_WIDTH + USER_WIDTH;

  arb_state_t        state;
  logic [IDX_W-1:0]  last_grant;
  logic [IDX_W-1:0]  sel;
  pick_t             pick;
  logic              grantable;
  logic              buf_ready;
  logic              buf_aresetn;
  logic              accept;
  logic              sel_last;
  logic [ID_WIDTH-1:0] beat_id;
  logic [BEAT_W-1:0] in_beat;
  logic [BEAT_W-1:0] out_beat;

  // Port selection: the held grant while locked, otherwise the round-robin
  // winner of this cycle. Ready is steered only to the selected port and is
  // forced low while reset is asserted.
  always_comb begin
    pick        = rr_pick(MAX_PORT'(src_t_valid), 32'(last_grant), N_PORT);
    sel         = grant_idx;
    grantable   = 1'b1;
    if (state == IDLE) begin
      sel       = IDX_W'(pick.idx);
      grantable = pick.found;
    end
    src_t_ready = '0;
    if (grantable && buf_ready && !areset) begin
      src_t_ready[sel] = 1'b1;
    end
    accept   = src_t_valid[sel] && src_t_ready[sel];
    sel_last = src_t_last[sel];
    beat_id  = (TAG_ID != 0) ? ID_WIDTH'(sel) : src_t_id[sel];
    in_beat  = {src_t_data[sel], src_t_strb[sel], src_t_keep[sel], sel_last,
                beat_id, src_t_dest[sel], src_t_user[sel]};
  end

  // A single-beat packet (t_last on the first beat) never enters LOCKED.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state      <= IDLE;
      last_grant <= IDX_W'(N_PORT - 1);
      grant_idx  <= '0;
      locked     <= 1'b0;
    end else if (accept) begin
      last_grant <= sel;
      grant_idx  <= sel;
      if (sel_last) begin
        state  <= IDLE;
        locked <= 1'b0;
      end else begin
        state  <= LOCKED;
        locked <= 1'b1;
      end
    end
  end

  assign buf_aresetn = ~areset;

  nasti_stream_buf #(
    .WIDTH    (BEAT_W),
    .BUF_SIZE (2)
  ) u_buf (
    .aclk      (aclk),
    .aresetn   (buf_aresetn),
    .in_valid  (accept),
    .in_ready  (buf_ready),
    .in_data   (in_beat),
    .out_valid (dest_t_valid),
    .out_ready (dest_t_ready),
    .out_data  (out_beat)
  );

  assign {dest_t_data, dest_t_strb, dest_t_keep, dest_t_last,
          dest_t_id, dest_t_dest, dest_t_user} = out_beat;

endmodule
